smpl_trigger: RTL and testbench
===============================

SMPL_TRIGGER -- requirements
Module: smpl_trigger

Interface
REQ-001 Parameter SN, 12, sample width in bits.
REQ-002 Parameter DIVN, 8, width of decimation ratio input.
REQ-003 Parameter TMO, 4096, auto-trigger timeout in accepted ADC samples.
REQ-004 clkSmpl  in  1  sample clock; one clock only; all logic on posedge clkSmpl.
REQ-005 n_reset  in  1  reset, asynchronous, active-low.
REQ-006 adc_valid  in  1  ADC sample strobe.
REQ-007 adc  in  SN  ADC sample, unsigned.
REQ-008 trig_level  in  SN  trigger threshold, unsigned.
REQ-009 trig_edge  in  1  1 = rising, 0 = falling.
REQ-010 trig_auto  in  1  1 = force trigger after TMO samples without an edge.
REQ-011 decim  in  DIVN  decimation; one output per decim+1 ADC samples.
REQ-012 smpl_req  in  1  downstream capture request; high = space available.
REQ-013 smpl_valid  out  1  one-cycle strobe, output sample present.
REQ-014 smpl  out  SN  output sample, held between strobes.
REQ-015 triggered  out  1  high while in Stream.

Function
REQ-016 The block SHALL have four states: Idle, Arm, Wait, Stream.
REQ-017 Idle -> Arm when smpl_req = 1; trig_level, trig_edge, trig_auto and decim SHALL be latched on that edge and stay constant until the next Idle.
REQ-018 Arm -> Wait on the first adc_valid, which only loads the previous-sample register prev; no trigger is possible in Arm.
REQ-019 In Wait, each adc_valid SHALL compare prev and adc: rising event = prev < level and adc >= level; falling event = prev > level and adc <= level; prev <= adc every adc_valid.
REQ-020 Wait -> Stream on an edge event, or when trig_auto = 1 and the timeout counter reaches TMO-1 on an adc_valid; an edge event and a timeout in the same cycle count as one trigger.
REQ-021 The timeout counter (clog2(TMO) bits) SHALL clear on entering Wait and count adc_valid cycles in Wait only.
REQ-022 The trigger sample SHALL be the first output; the decimation counter SHALL reset to 0 on that sample.
REQ-023 In Stream, each adc_valid SHALL increment the decimation counter; when it equals decim, the sample is output and the counter wraps to 0; decim = 0 outputs every sample.
REQ-024 Output latency SHALL be one cycle: adc_valid at edge N -> smpl_valid high for the cycle after edge N+1, with smpl = that adc value.
REQ-025 smpl_valid SHALL NOT be asserted when smpl_req = 0 at the emitting edge; that sample is dropped.
REQ-026 Arm, Wait or Stream -> Idle when smpl_req = 0; this takes priority over a simultaneous trigger or emission.
REQ-027 smpl_valid SHALL never be asserted outside Stream, except for the trigger sample of REQ-022.
REQ-028 triggered SHALL be registered and equal (state == Stream).

Reset
REQ-029 On n_reset low: state = Idle, smpl_valid = 0, smpl = 0, triggered = 0, prev = 0, all counters = 0, latched config = 0.
REQ-030 Reset mid-capture SHALL abort immediately with no further smpl_valid; after release the block restarts from Idle.

Structure
REQ-031 The state enum and the edge encoding constants SHALL live in shared package smpl_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; all outputs SHALL be registered.

Verification
REQ-033 Rising trigger: level=2048, rising, decim=0, ramp 2000,2040,2050,2060 with smpl_req=1 -> first smpl_valid carries 2050, then 2060; triggered rises with 2050.
REQ-034 Decimation: decim=3 after trigger on sample value 100, samples 101..112 -> outputs 100,104,108,112.
REQ-035 Falling trigger: level=1000, falling, sequence 1200,1000 -> trigger on 1000; a rising crossing 900->1100 gives no trigger.
REQ-036 Auto trigger: TMO=16, trig_auto=1, constant adc=5 -> trigger on the 16th adc_valid in Wait, first output 5; with trig_auto=0, no output after 100 samples.
REQ-037 smpl_req drop: in Stream, deassert smpl_req on the same cycle as an emission -> no smpl_valid, state Idle next cycle; reassert -> Arm, and an edge at the first sample is ignored.
REQ-038 Reset: assert n_reset in Stream mid-burst -> smpl_valid and triggered are 0 at once; after release with smpl_req=1 -> Arm.

Source files
------------

// File: rtl/smpl_pkg.sv
// Shared types for the sample trigger: FSM states
// and trigger-edge encodings.
package smpl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_STREAM
  } state_e;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

endpackage

// File: rtl/smpl_trigger.sv
// Scope-style trigger: arms on smpl_req, waits for a level
// crossing (or auto timeout), then streams decimated samples.
// Ports: clkSmpl/n_reset; adc_valid/adc in; trig_level,
// trig_edge, trig_auto, decim config; smpl_req handshake;
// smpl_valid/smpl registered output; triggered status.
module smpl_trigger
  import smpl_pkg::*;
#(
  parameter int SN   = 12,
  parameter int DIVN = 8,
  parameter int TMO  = 4096
) (
  input  logic            clkSmpl,
  input  logic            n_reset,
  input  logic            adc_valid,
  input  logic [SN-1:0]   adc,
  input  logic [SN-1:0]   trig_level,
  input  logic            trig_edge,
  input  logic            trig_auto,
  input  logic [DIVN-1:0] decim,
  input  logic            smpl_req,
  output logic            smpl_valid,
  output logic [SN-1:0]   smpl,
  output logic            triggered
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_e          st_q, st_d;
  logic [SN-1:0]   lvl_q, lvl_d;
  logic            edge_q, edge_d;
  logic            auto_q, auto_d;
  logic [DIVN-1:0] decim_q, decim_d;
  logic [SN-1:0]   prev_q, prev_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DIVN-1:0] dcnt_q, dcnt_d;
  logic            emit_q, emit_d;
  logic [SN-1:0]   data_q, data_d;
  logic            vld_q, vld_d;
  logic [SN-1:0]   smpl_q, smpl_d;
  logic            trig_q, trig_d;

  logic hit_rise, hit_fall, edge_hit, tmo_hit;

  assign hit_rise = (prev_q < lvl_q) && (adc >= lvl_q);
  assign hit_fall = (prev_q > lvl_q) && (adc <= lvl_q);
  assign edge_hit = (edge_q == EDGE_RISE) ? hit_rise
                                          : hit_fall;
  assign tmo_hit  = auto_q && (tmo_q == TMO_LAST);

  always_comb begin
    st_d    = st_q;
    lvl_d   = lvl_q;
    edge_d  = edge_q;
    auto_d  = auto_q;
    decim_d = decim_q;
    prev_d  = prev_q;
    tmo_d   = tmo_q;
    dcnt_d  = dcnt_q;
    emit_d  = 1'b0;
    data_d  = data_q;
    unique case (st_q)
      ST_IDLE: begin
        if (smpl_req) begin
          st_d    = ST_ARM;
          lvl_d   = trig_level;
          edge_d  = trig_edge;
          auto_d  = trig_auto;
          decim_d = decim;
        end
      end
      ST_ARM: begin
        if (!smpl_req) begin
          st_d = ST_IDLE;
        end else if (adc_valid) begin
          st_d   = ST_WAIT;
          prev_d = adc;
          tmo_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!smpl_req) begin
          st_d = ST_IDLE;
        end else if (adc_valid) begin
          prev_d = adc;
          if (edge_hit || tmo_hit) begin
            st_d   = ST_STREAM;
            emit_d = 1'b1;
            data_d = adc;
            dcnt_d = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (!smpl_req) begin
          st_d = ST_IDLE;
        end else if (adc_valid) begin
          if (dcnt_q == decim_q) begin
            emit_d = 1'b1;
            data_d = adc;
            dcnt_d = '0;
          end else begin
            dcnt_d = dcnt_q + DIVN'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Output stage: a sample dropped by smpl_req going low
  // here never shows up, and triggered lines up with the
  // first streamed sample.
  always_comb begin
    vld_d  = emit_q && smpl_req;
    smpl_d = vld_d ? data_q : smpl_q;
    trig_d = (st_q == ST_STREAM);
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      st_q    <= ST_IDLE;
      lvl_q   <= '0;
      edge_q  <= 1'b0;
      auto_q  <= 1'b0;
      decim_q <= '0;
      prev_q  <= '0;
      tmo_q   <= '0;
      dcnt_q  <= '0;
      emit_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      smpl_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      lvl_q   <= lvl_d;
      edge_q  <= edge_d;
      auto_q  <= auto_d;
      decim_q <= decim_d;
      prev_q  <= prev_d;
      tmo_q   <= tmo_d;
      dcnt_q  <= dcnt_d;
      emit_q  <= emit_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      smpl_q  <= smpl_d;
      trig_q  <= trig_d;
    end
  end

  assign smpl_valid = vld_q;
  assign smpl       = smpl_q;
  assign triggered  = trig_q;

endmodule

// File: tb/tb_smpl_trigger.sv
// Directed bench for smpl_trigger: one task per scenario,
// inline comparisons, single summary line.
module tb_smpl_trigger;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc = '0;
  logic [11:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic        trig_auto = 1'b0;
  logic [7:0]  decim = '0;
  logic        smpl_req = 1'b0;
  logic        smpl_valid;
  logic [11:0] smpl;
  logic        triggered;

  int n_cmp = 0;
  int n_err = 0;
  int got[$];

  always #5 clk = ~clk;

  smpl_trigger #(.SN(12), .DIVN(8), .TMO(16)) dut (
    .clkSmpl    (clk),
    .n_reset    (n_reset),
    .adc_valid  (adc_valid),
    .adc        (adc),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_auto  (trig_auto),
    .decim      (decim),
    .smpl_req   (smpl_req),
    .smpl_valid (smpl_valid),
    .smpl       (smpl),
    .triggered  (triggered)
  );

  always @(negedge clk)
    if (smpl_valid) got.push_back(int'(smpl));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int v);
    adc = 12'(v);
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic flush();
    tick();
    tick();
    tick();
  endtask

  task automatic start(input int lvl, input logic e,
                       input logic au, input int dc);
    smpl_req = 1'b0;
    tick();
    tick();
    trig_level = 12'(lvl);
    trig_edge = e;
    trig_auto = au;
    decim = 8'(dc);
    smpl_req = 1'b1;
    got.delete();
    tick();
  endtask

  task automatic chk_q(input string nm, input int idx,
                       input int exp);
    n_cmp++;
    if (idx >= got.size()) begin
      n_err++;
      $display("FAIL %s: got no sample %0d, required %0d",
               nm, idx, exp);
    end else if (got[idx] != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d",
               nm, got[idx], exp);
    end
  endtask

  task automatic chk_n(input string nm, input int exp);
    n_cmp++;
    if (got.size() != exp) begin
      n_err++;
      $display("FAIL %s: count %0d, required %0d",
               nm, got.size(), exp);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (smpl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid: got %b, required 0",
               smpl_valid);
    end
    n_cmp++;
    if (smpl !== 12'd0) begin
      n_err++;
      $display("FAIL rst_smpl: got %0d, required 0", smpl);
    end
    n_cmp++;
    if (triggered !== 1'b0) begin
      n_err++;
      $display("FAIL rst_trig: got %b, required 0",
               triggered);
    end
    tick();
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_rising();
    start(2048, 1'b1, 1'b0, 0);
    sample(2000);
    sample(2040);
    sample(2050);
    n_cmp++;
    if (smpl_valid !== 1'b0 || triggered !== 1'b0) begin
      n_err++;
      $display("FAIL rise_early: valid %b trig %b, required 0 0",
               smpl_valid, triggered);
    end
    sample(2060);
    n_cmp++;
    if (smpl_valid !== 1'b1 || smpl !== 12'd2050) begin
      n_err++;
      $display("FAIL rise_first: valid %b smpl %0d, required 1 2050",
               smpl_valid, smpl);
    end
    n_cmp++;
    if (triggered !== 1'b1) begin
      n_err++;
      $display("FAIL rise_trig: got %b, required 1", triggered);
    end
    flush();
    chk_n("rise_count", 2);
    chk_q("rise_s1", 1, 2060);
  endtask

  task automatic test_decim();
    start(50, 1'b1, 1'b0, 3);
    sample(10);
    for (int v = 100; v <= 112; v++) sample(v);
    flush();
    chk_n("dec_count", 4);
    chk_q("dec_s0", 0, 100);
    chk_q("dec_s1", 1, 104);
    chk_q("dec_s2", 2, 108);
    chk_q("dec_s3", 3, 112);
  endtask

  task automatic test_falling();
    start(1000, 1'b0, 1'b0, 0);
    // config pins change after arming; latched copy rules
    trig_level = 12'd0;
    trig_edge = 1'b1;
    sample(900);
    sample(1100);
    sample(1200);
    sample(1000);
    sample(950);
    flush();
    chk_n("fall_count", 2);
    chk_q("fall_s0", 0, 1000);
    chk_q("fall_s1", 1, 950);
  endtask

  task automatic test_auto();
    start(4095, 1'b1, 1'b1, 0);
    sample(5);
    for (int i = 0; i < 15; i++) sample(5);
    flush();
    chk_n("auto_15", 0);
    sample(5);
    flush();
    chk_n("auto_16", 1);
    chk_q("auto_s0", 0, 5);
    start(4095, 1'b1, 1'b0, 0);
    for (int i = 0; i < 101; i++) sample(5);
    flush();
    chk_n("noauto", 0);
    n_cmp++;
    if (triggered !== 1'b0) begin
      n_err++;
      $display("FAIL noauto_trig: got %b, required 0",
               triggered);
    end
  endtask

  task automatic test_req_drop();
    start(2048, 1'b1, 1'b0, 1);
    sample(2000);
    sample(2100);
    sample(2101);
    adc = 12'd2102;
    adc_valid = 1'b1;
    smpl_req = 1'b0;
    tick();
    adc_valid = 1'b0;
    n_cmp++;
    if (smpl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_valid: got %b, required 0",
               smpl_valid);
    end
    tick();
    n_cmp++;
    if (triggered !== 1'b0 || smpl_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: trig %b valid %b, required 0 0",
               triggered, smpl_valid);
    end
    chk_n("drop_count", 1);
    chk_q("drop_s0", 0, 2100);
    trig_level = 12'd3000;
    smpl_req = 1'b1;
    got.delete();
    tick();
    sample(3100);
    sample(3200);
    flush();
    chk_n("rearm_ignore", 0);
    sample(2900);
    sample(3050);
    flush();
    chk_n("rearm_count", 1);
    chk_q("rearm_s0", 0, 3050);
  endtask

  task automatic test_reset_mid();
    start(2048, 1'b1, 1'b0, 0);
    sample(2000);
    sample(2100);
    sample(2200);
    n_cmp++;
    if (smpl_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: got %b, required 1", smpl_valid);
    end
    n_reset = 1'b0;
    #1;
    n_cmp++;
    if (smpl_valid !== 1'b0 || triggered !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst: valid %b trig %b, required 0 0",
               smpl_valid, triggered);
    end
    got.delete();
    adc = 12'd2400;
    adc_valid = 1'b1;
    tick();
    tick();
    adc_valid = 1'b0;
    chk_n("mid_hold", 0);
    n_reset = 1'b1;
    tick();
    sample(2500);
    sample(2600);
    flush();
    chk_n("post_arm", 0);
    sample(2000);
    sample(2100);
    flush();
    chk_n("post_count", 1);
    chk_q("post_s0", 0, 2100);
  endtask

  initial begin
    test_reset();
    test_rising();
    test_decim();
    test_falling();
    test_auto();
    test_req_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
